dmem_mmio: RTL and testbench

- Data-memory stage directly downstream of the single-cycle `mips` core.
- Consumes the core's `aluout` (address), `writedata` and `memwrite`, and returns `readdata` in the same cycle.
- Contains a word-addressed data RAM plus a small memory-mapped I/O window: GPIO output register, free-running cycle counter, and a compare timer with a sticky interrupt flag.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/mmio_timer.sv | 67 ++++++
 rtl/dmem_mmio.sv | 91 +++++++++
 tb/tb_dmem_mmio.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory stage: MMIO window base, register offsets, STATUS bits.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dmem_pkg;

    localparam logic [23:0] MMIO_BASE = 24'hFFFFFF;

    localparam logic [7:0] GPIO_OFF  = 8'h00;
    localparam logic [7:0] CYCLE_OFF = 8'h04;
    localparam logic [7:0] TCMP_OFF  = 8'h08;
    localparam logic [7:0] TCNT_OFF  = 8'h0C;
    localparam logic [7:0] STAT_OFF  = 8'h10;

    localparam int IRQ_BIT = 0;
    localparam int EN_BIT  = 1;

endpackage

// File: rtl/mmio_timer.sv
// Free-running cycle counter plus compare timer with sticky, write-1-to-clear interrupt flag.
// Latency: register values update on the clock edge; reads are direct register taps.
// Backpressure: none, a write strobe is always accepted.
module mmio_timer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [7:0]  off,
    input  logic [31:0] wdata,
    output logic [31:0] cycle,
    output logic [31:0] tcmp,
    output logic [31:0] tcnt,
    output logic        en,
    output logic        irq
);

    logic tcmp_we;
    logic tcnt_we;
    logic stat_we;
    logic match;

    always_comb begin
        tcmp_we = we && (off == TCMP_OFF);
        tcnt_we = we && (off == TCNT_OFF);
        stat_we = we && (off == STAT_OFF);
        // A value loaded into TCNT this cycle is not compared until the next one.
        match   = en && !tcnt_we && (tcnt == tcmp);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle <= '0;
            tcmp  <= '0;
            tcnt  <= '0;
            en    <= 1'b0;
            irq   <= 1'b0;
        end else begin
            cycle <= cycle + 32'd1;

            if (tcmp_we) begin
                tcmp <= wdata;
            end

            if (tcnt_we) begin
                tcnt <= wdata;
            end else if (match) begin
                tcnt <= '0;
            end else if (en) begin
                tcnt <= tcnt + 32'd1;
            end

            if (stat_we) begin
                en <= wdata[EN_BIT];
            end

            // Hardware set wins over a same-cycle software clear.
            if (match) begin
                irq <= 1'b1;
            end else if (stat_we && wdata[IRQ_BIT]) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM plus MMIO window (GPIO, cycle counter, compare timer).
// Latency: loads are combinational; stores land on the clock edge.
// Backpressure: none, every access completes in its own cycle.
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter int          AW        = 6,
    parameter logic [23:0] MMIO_BASE = dmem_pkg::MMIO_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  gpio_out,
    output logic        timer_irq
);

    logic [31:0] mem [DEPTH];

    logic          mmio_sel;
    logic [7:0]    off;
    logic [AW-1:0] idx;
    logic          wr_en;
    logic          mmio_we;
    logic          ram_we;

    logic [7:0]  gpio;
    logic [31:0] cycle;
    logic [31:0] tcmp;
    logic [31:0] tcnt;
    logic        en;
    logic        irq;

    always_comb begin
        mmio_sel = (aluout[31:8] == MMIO_BASE);
        off      = aluout[7:0];
        idx      = aluout[AW+1:2];
        // Stores are dropped while reset is held low.
        wr_en    = memwrite && reset;
        mmio_we  = wr_en && mmio_sel;
        ram_we   = wr_en && !mmio_sel;
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[idx] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio <= '0;
        end else if (mmio_we && (off == GPIO_OFF)) begin
            gpio <= writedata[7:0];
        end
    end

    mmio_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .we    (mmio_we),
        .off   (off),
        .wdata (writedata),
        .cycle (cycle),
        .tcmp  (tcmp),
        .tcnt  (tcnt),
        .en    (en),
        .irq   (irq)
    );

    always_comb begin
        readdata = mem[idx];
        if (mmio_sel) begin
            case (off)
                GPIO_OFF:  readdata = {24'd0, gpio};
                CYCLE_OFF: readdata = cycle;
                TCMP_OFF:  readdata = tcmp;
                TCNT_OFF:  readdata = tcnt;
                STAT_OFF:  readdata = {30'd0, en, irq};
                default:   readdata = 32'd0;
            endcase
        end
    end

    assign gpio_out  = gpio;
    assign timer_irq = irq;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed bench for dmem_mmio: RAM, GPIO, cycle counter, timer/IRQ races and async reset.
module tb_dmem_mmio;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    int passes = 0;
    int total  = 0;

    dmem_mmio dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        aluout    = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        memwrite = 1'b0;
        aluout   = a;
        #1;
        check(tag, readdata, exp);
    endtask

    initial begin
        reset     = 1'b0;
        memwrite  = 1'b0;
        aluout    = 32'd0;
        writedata = 32'd0;
        #2;

        // Held in reset: outputs cleared, MMIO reads zero, stores dropped.
        check("rst_gpio", {24'd0, gpio_out}, 32'd0);
        check("rst_irq", {31'd0, timer_irq}, 32'd0);
        load_check("rst_cycle", 32'hFFFFFF04, 32'd0);
        store(32'hFFFFFF00, 32'h000000FF);
        check("rst_gpio_store", {24'd0, gpio_out}, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        load_check("cycle_start", 32'hFFFFFF04, 32'd0);

        // edge 1: RAM store, then read back and through the wrapped alias.
        store(32'h00000010, 32'hDEADBEEF);
        load_check("ram_rd", 32'h00000010, 32'hDEADBEEF);
        load_check("ram_wrap", 32'h00000110, 32'hDEADBEEF);
        load_check("ram_byte_ofs", 32'h00000013, 32'hDEADBEEF);

        // edge 2: GPIO keeps the low byte only.
        store(32'hFFFFFF00, 32'h000001A5);
        check("gpio_out", {24'd0, gpio_out}, 32'h000000A5);
        load_check("gpio_rd", 32'hFFFFFF00, 32'h000000A5);

        // edge 3: CYCLE is read-only.
        store(32'hFFFFFF04, 32'h00001234);
        load_check("cycle_ro", 32'hFFFFFF04, 32'd3);

        // edge 4: unmapped offset.
        load_check("unmapped_rd", 32'hFFFFFF40, 32'd0);
        store(32'hFFFFFF40, 32'hFFFFFFFF);
        check("unmapped_gpio", {24'd0, gpio_out}, 32'h000000A5);
        load_check("unmapped_tcmp", 32'hFFFFFF08, 32'd0);
        load_check("unmapped_tcnt", 32'hFFFFFF0C, 32'd0);
        load_check("unmapped_stat", 32'hFFFFFF10, 32'd0);
        load_check("unmapped_14", 32'hFFFFFF14, 32'd0);
        load_check("cycle_4", 32'hFFFFFF04, 32'd4);

        // edges 5-7: TCMP=3, TCNT=0, EN=1.
        store(32'hFFFFFF08, 32'd3);
        store(32'hFFFFFF0C, 32'd0);
        store(32'hFFFFFF10, 32'h00000002);
        load_check("tcmp_rd", 32'hFFFFFF08, 32'd3);
        load_check("stat_en", 32'hFFFFFF10, 32'h00000002);

        // Edges 1-3 after EN count 0->3, edge 4 matches.
        tick();
        tick();
        tick();
        load_check("tcnt_3", 32'hFFFFFF0C, 32'd3);
        check("irq_pre", {31'd0, timer_irq}, 32'd0);
        tick();
        check("irq_set", {31'd0, timer_irq}, 32'd1);
        load_check("tcnt_wrap0", 32'hFFFFFF0C, 32'd0);
        load_check("stat_irq_en", 32'hFFFFFF10, 32'h00000003);

        // W1C in the same cycle as a match: flag stays set.
        tick();
        tick();
        tick();
        store(32'hFFFFFF10, 32'h00000003);
        check("w1c_race", {31'd0, timer_irq}, 32'd1);
        load_check("w1c_race_tcnt", 32'hFFFFFF0C, 32'd0);

        // W1C in a non-match cycle clears it, EN retained.
        store(32'hFFFFFF10, 32'h00000003);
        check("w1c_clear", {31'd0, timer_irq}, 32'd0);
        load_check("w1c_stat", 32'hFFFFFF10, 32'h00000002);

        // TCNT write at a would-be match edge: load wins, no IRQ.
        tick();
        tick();
        load_check("tcnt_pre_wr", 32'hFFFFFF0C, 32'd3);
        store(32'hFFFFFF0C, 32'h00000010);
        check("tcnt_wr_noirq", {31'd0, timer_irq}, 32'd0);
        load_check("tcnt_wr_val", 32'hFFFFFF0C, 32'h00000010);

        // Load TCNT=3 (not compared this edge), next edge matches.
        store(32'hFFFFFF0C, 32'd3);
        check("tcnt_ld_noirq", {31'd0, timer_irq}, 32'd0);
        tick();
        check("irq_set2", {31'd0, timer_irq}, 32'd1);
        load_check("cycle_21", 32'hFFFFFF04, 32'd21);

        repeat (11) tick();
        load_check("cycle_20h", 32'hFFFFFF04, 32'h00000020);
        check("gpio_hold", {24'd0, gpio_out}, 32'h000000A5);

        // Async reset pulse between edges.
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_gpio", {24'd0, gpio_out}, 32'd0);
        check("mid_rst_irq", {31'd0, timer_irq}, 32'd0);
        load_check("mid_rst_cycle", 32'hFFFFFF04, 32'd0);
        load_check("mid_rst_tcmp", 32'hFFFFFF08, 32'd0);
        load_check("mid_rst_ram", 32'h00000010, 32'hDEADBEEF);
        reset = 1'b1;
        tick();
        load_check("post_rst_cycle", 32'hFFFFFF04, 32'd1);
        load_check("post_rst_stat", 32'hFFFFFF10, 32'd0);
        check("post_rst_irq", {31'd0, timer_irq}, 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
